reglist_sequencer: RTL and testbench

Sequences ARMv4 LDM/STM block transfers. Walks a 16-bit register list one set bit per transfer, using the existing priority one_detector to select the next register. Emits register index and word address per beat over a valid/ready handshake to the load/store stage, then returns the written-back base. Sits between decode and the memory access stage.

---
 rtl/reglist_sequencer_pkg.sv | 19 +
 rtl/reglist_sequencer_if.sv | 41 ++++
 rtl/reglist_sequencer_one_detector.sv | 26 ++
 rtl/reglist_sequencer.sv | 134 +++++++++++++
 tb/tb_reglist_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reglist_sequencer_pkg.sv
// Shared types and constants for the LDM/STM register-list sequencer.
//   state_e   : sequencer state (IDLE / XFER / DONE)
//   STEP_BYTES: default byte increment per transferred word
//   reglist_t : 16-bit register list, bit n = Rn
//   reg_idx_t : 4-bit register index
package reglist_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE
  } state_e;

  localparam int unsigned STEP_BYTES = 4;

  typedef logic [15:0] reglist_t;
  typedef logic [3:0]  reg_idx_t;

endpackage

// File: rtl/reglist_sequencer_if.sv
// Bus between decode / load-store stage and the register-list sequencer.
//   i_start, i_reglist, i_up, i_pre, i_base : launch request from decode
//   i_ready, i_abort                       : flow control / abort from memory stage
//   o_valid, o_reg, o_addr, o_last         : per-beat transfer presentation
//   o_busy, o_done, o_wb_base, o_count     : sequence status and written-back base
// slave  : the sequencer side
// master : the side driving the request and consuming beats
interface reglist_sequencer_if
  import reglist_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);

  logic              i_start;
  reglist_t          i_reglist;
  logic              i_up;
  logic              i_pre;
  logic [ADDR_W-1:0] i_base;
  logic              i_ready;
  logic              i_abort;

  logic              o_valid;
  reg_idx_t          o_reg;
  logic [ADDR_W-1:0] o_addr;
  logic              o_last;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W-1:0] o_wb_base;
  logic [4:0]        o_count;

  modport slave (
    input  i_start, i_reglist, i_up, i_pre, i_base, i_ready, i_abort,
    output o_valid, o_reg, o_addr, o_last, o_busy, o_done, o_wb_base, o_count
  );

  modport master (
    output i_start, i_reglist, i_up, i_pre, i_base, i_ready, i_abort,
    input  o_valid, o_reg, o_addr, o_last, o_busy, o_done, o_wb_base, o_count
  );

endinterface

// File: rtl/reglist_sequencer_one_detector.sv
// Priority one detector over a 16-bit register list.
//   i_code  : bit vector to search
//   i_order : 1 = return lowest set bit, 0 = return highest set bit
//   o_index : index of the selected bit (0 when i_code is all zero)
module one_detector
  import reglist_sequencer_pkg::*;
(
  input  reglist_t i_code,
  input  logic     i_order,
  output reg_idx_t o_index
);

  // The last match in scan order wins, so scan from the opposite end
  // of the bit that should have priority.
  always_comb begin
    o_index = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i_order) begin
        if (i_code[15-i]) o_index = reg_idx_t'(15 - i);
      end else begin
        if (i_code[i]) o_index = reg_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/reglist_sequencer.sv
// ARMv4 LDM/STM block-transfer sequencer. Walks the register list one set
// bit per beat, presenting register index and word address to the
// load/store stage over a valid/ready handshake, then reports the
// written-back base.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : request, beat handshake and status (see reglist_sequencer_if)
module reglist_sequencer
  import reglist_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STEP   = STEP_BYTES
) (
  input  logic                i_clk,
  input  logic                i_rst,
  reglist_sequencer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  state_e            state_q, state_d;
  reglist_t          remaining_q, remaining_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        count_q, count_d;
  logic [ADDR_W-1:0] final_q, final_d;
  logic [ADDR_W-1:0] wb_base_q, wb_base_d;

  reg_idx_t          cur_reg;
  logic              cur_last;
  logic [4:0]        pop;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] start_final;
  logic [ADDR_W-1:0] start_addr;

  one_detector u_one_detector (
    .i_code  (remaining_q),
    .i_order (dir_q),
    .o_index (cur_reg)
  );

  // Exactly one bit left: nonzero and clearing the lowest set bit empties it.
  assign cur_last = (state_q == ST_XFER) && (remaining_q != '0) &&
                    ((remaining_q & (remaining_q - reglist_t'(1))) == '0);

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      pop = pop + 5'(bus.i_reglist[i]);
    end
  end

  assign span        = ADDR_W'(pop) * STEP_W;
  assign start_final = bus.i_up ? (bus.i_base + span) : (bus.i_base - span);
  assign start_addr  = bus.i_up ? (bus.i_pre ? bus.i_base + STEP_W : bus.i_base)
                                : (bus.i_pre ? bus.i_base - STEP_W : bus.i_base);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    addr_d      = addr_q;
    count_d     = count_q;
    final_d     = final_q;
    wb_base_d   = wb_base_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          remaining_d = bus.i_reglist;
          dir_d       = bus.i_up;
          addr_d      = start_addr;
          count_d     = '0;
          final_d     = start_final;
          if (bus.i_reglist == '0) begin
            // Empty list skips XFER, so the base is published directly.
            state_d   = ST_DONE;
            wb_base_d = start_final;
          end else begin
            state_d   = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (bus.i_abort) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (bus.i_ready) begin
          remaining_d = remaining_q & ~(reglist_t'(1) << cur_reg);
          addr_d      = dir_q ? (addr_q + STEP_W) : (addr_q - STEP_W);
          count_d     = count_q + 5'd1;
          if (cur_last) begin
            state_d   = ST_DONE;
            wb_base_d = final_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      final_q     <= '0;
      wb_base_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      final_q     <= final_d;
      wb_base_q   <= wb_base_d;
    end
  end

  assign bus.o_valid   = (state_q == ST_XFER);
  assign bus.o_reg     = cur_reg;
  assign bus.o_addr    = addr_q;
  assign bus.o_last    = cur_last;
  assign bus.o_busy    = (state_q != ST_IDLE);
  assign bus.o_done    = (state_q == ST_DONE);
  assign bus.o_wb_base = wb_base_q;
  assign bus.o_count   = count_q;

endmodule

// File: tb/tb_reglist_sequencer.sv
module tb_reglist_sequencer;

  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reglist_sequencer_if #(.ADDR_W(AW)) bus ();

  reglist_sequencer #(.ADDR_W(AW), .STEP(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: a sequence is a precomputed list of (reg, addr)
  // beats; accepting a beat pops the head of the list.
  typedef struct {
    logic [3:0]  r;
    logic [31:0] a;
  } beat_t;

  beat_t       q[$];
  bit          m_active;
  bit          m_done;
  int          m_count;
  logic [31:0] m_wb;
  logic [31:0] m_final;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0;
    m_done   = 0;
    m_count  = 0;
    m_wb     = '0;
    m_final  = '0;
  endtask

  task automatic model_step();
    if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (bus.i_abort) begin
        m_active = 0;
        q.delete();
      end else if (bus.i_ready) begin
        void'(q.pop_front());
        m_count++;
        if (q.size() == 0) begin
          m_active = 0;
          m_done   = 1;
          m_wb     = m_final;
        end
      end
    end else if (bus.i_start) begin
      logic [31:0] a;
      int n;
      q.delete();
      n = 0;
      a = bus.i_base;
      if (bus.i_pre) a = bus.i_up ? a + 32'd4 : a - 32'd4;
      for (int k = 0; k < 16; k++) begin
        int r;
        r = bus.i_up ? k : 15 - k;
        if (bus.i_reglist[r]) begin
          q.push_back('{r: 4'(r), a: a});
          a = bus.i_up ? a + 32'd4 : a - 32'd4;
          n++;
        end
      end
      m_final = bus.i_up ? bus.i_base + 32'(4 * n) : bus.i_base - 32'(4 * n);
      m_count = 0;
      if (n == 0) begin
        m_done = 1;
        m_wb   = m_final;
      end else begin
        m_active = 1;
      end
    end
  endtask

  task automatic compare();
    chk("valid", bus.o_valid, m_active);
    chk("busy", bus.o_busy, m_active || m_done);
    chk("done", bus.o_done, m_done);
    chk("last", bus.o_last, m_active && (q.size() == 1));
    chk("count", bus.o_count, m_count);
    chk("wb_base", bus.o_wb_base, m_wb);
    if (m_active) begin
      chk("reg", bus.o_reg, q[0].r);
      chk("addr", bus.o_addr, q[0].a);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic launch(input logic [15:0] rl, input logic up, input logic pre, input logic [31:0] base);
    bus.i_start   = 1'b1;
    bus.i_reglist = rl;
    bus.i_up      = up;
    bus.i_pre     = pre;
    bus.i_base    = base;
    tick();
    bus.i_start   = 1'b0;
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 40 && (m_active || m_done); i++) tick();
    chk("idle_timeout", bus.o_busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.i_start   = 1'b0;
    bus.i_reglist = '0;
    bus.i_up      = 1'b1;
    bus.i_pre     = 1'b0;
    bus.i_base    = '0;
    bus.i_ready   = 1'b1;
    bus.i_abort   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_count", bus.o_count, 5'd0);
    rst = 1'b0;
    tick();

    // IA
    launch(16'h8011, 1'b1, 1'b0, 32'h1000);
    chk("ia_b0_reg", bus.o_reg, 4'd0);
    chk("ia_b0_addr", bus.o_addr, 32'h1000);
    tick();
    chk("ia_b1_reg", bus.o_reg, 4'd4);
    chk("ia_b1_addr", bus.o_addr, 32'h1004);
    tick();
    chk("ia_b2_reg", bus.o_reg, 4'd15);
    chk("ia_b2_addr", bus.o_addr, 32'h1008);
    chk("ia_b2_last", bus.o_last, 1'b1);
    tick();
    chk("ia_done", bus.o_done, 1'b1);
    chk("ia_wb", bus.o_wb_base, 32'h100C);
    chk("ia_count", bus.o_count, 5'd3);
    tick();

    // DB
    launch(16'h000E, 1'b0, 1'b1, 32'h2000);
    chk("db_b0_reg", bus.o_reg, 4'd3);
    chk("db_b0_addr", bus.o_addr, 32'h1FFC);
    tick();
    tick();
    chk("db_b2_reg", bus.o_reg, 4'd1);
    chk("db_b2_addr", bus.o_addr, 32'h1FF4);
    tick();
    chk("db_wb", bus.o_wb_base, 32'h1FF4);
    tick();

    // Backpressure (IB)
    bus.i_ready = 1'b0;
    launch(16'h0003, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_reg", bus.o_reg, 4'd0);
      chk("bp_hold_addr", bus.o_addr, 32'h4);
      if (i < 2) tick();
    end
    bus.i_ready = 1'b1;
    tick();
    chk("bp_b1_reg", bus.o_reg, 4'd1);
    chk("bp_b1_addr", bus.o_addr, 32'h8);
    tick();
    chk("bp_wb", bus.o_wb_base, 32'h8);
    tick();

    // Empty list
    launch(16'h0000, 1'b1, 1'b0, 32'h40);
    chk("empty_valid", bus.o_valid, 1'b0);
    chk("empty_done", bus.o_done, 1'b1);
    chk("empty_wb", bus.o_wb_base, 32'h40);
    chk("empty_count", bus.o_count, 5'd0);
    tick();

    // Abort on third beat, then relaunch
    launch(16'hFFFF, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    chk("ab_b2_reg", bus.o_reg, 4'd2);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("ab_busy", bus.o_busy, 1'b0);
    chk("ab_done", bus.o_done, 1'b0);
    chk("ab_count", bus.o_count, 5'd2);
    chk("ab_wb", bus.o_wb_base, 32'h40);
    launch(16'h0001, 1'b1, 1'b0, 32'h100);
    chk("ab_re_reg", bus.o_reg, 4'd0);
    chk("ab_re_last", bus.o_last, 1'b1);
    tick();
    chk("ab_re_wb", bus.o_wb_base, 32'h104);
    chk("ab_re_count", bus.o_count, 5'd1);
    tick();

    // Address wrap
    launch(16'h0003, 1'b1, 1'b0, 32'hFFFF_FFFC);
    chk("wr_b0_addr", bus.o_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_b1_addr", bus.o_addr, 32'h0);
    tick();
    chk("wr_wb", bus.o_wb_base, 32'h4);
    tick();

    // Reset mid-XFER
    launch(16'hFFFF, 1'b1, 1'b0, 32'h500);
    tick();
    rst = 1'b1;
    #1;
    chk("mr_valid", bus.o_valid, 1'b0);
    chk("mr_reg", bus.o_reg, 4'd0);
    chk("mr_addr", bus.o_addr, 32'h0);
    chk("mr_last", bus.o_last, 1'b0);
    chk("mr_busy", bus.o_busy, 1'b0);
    chk("mr_done", bus.o_done, 1'b0);
    chk("mr_wb", bus.o_wb_base, 32'h0);
    chk("mr_count", bus.o_count, 5'd0);
    model_reset();
    #1;
    rst = 1'b0;
    tick();

    // Randomized traffic, inputs redrawn every cycle
    for (int c = 0; c < 3000; c++) begin
      int sel;
      sel = $urandom_range(0, 9);
      bus.i_start = ($urandom_range(0, 9) < 3);
      case (sel)
        0:       bus.i_reglist = 16'h0000;
        1:       bus.i_reglist = 16'hFFFF;
        2:       bus.i_reglist = 16'(1) << $urandom_range(0, 15);
        default: bus.i_reglist = 16'($urandom);
      endcase
      bus.i_up    = 1'($urandom);
      bus.i_pre   = 1'($urandom);
      bus.i_base  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                : $urandom;
      bus.i_ready = ($urandom_range(0, 9) < 7);
      bus.i_abort = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_ready = 1'b1;
    run_to_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
